seq_packet_bus_sink: RTL and testbench
======================================

SEQ_PACKET_BUS_SINK -- requirements
Module: seq_packet_bus_sink

Interface
REQ-001 SHALL have parameter COUNT_BITS, default 32, width of job and sequence counters.
REQ-002 SHALL use widths from parameters.vh: P=`SEQ_PACKET_SIZE, LLB=`SEQ_LL_BITS, MLB=`SEQ_ML_BITS, OFB=`SEQ_OFFSET_BITS.
REQ-003 SHALL have one clock; reset is asynchronous and active-high: clk input 1, rising-edge clock; rst input 1, asynchronous active-high reset.
REQ-004 bus_i_valid input 1; packet valid from the last bus node.
REQ-005 bus_i_mask input P; bit k set = slot k holds a sequence.
REQ-006 bus_i_ll / bus_i_ml / bus_i_offset input LLB*P / MLB*P / OFB*P; slot k in bits [k*W +: W].
REQ-007 bus_i_overlap input MLB; bus_i_eoj input 1, end of job; bus_i_delim input 1, block delimiter.
REQ-008 bus_i_ready output 1; sink accepts packet.
REQ-009 seq_o_valid output 1; seq_o_ready input 1; one sequence beat per handshake.
REQ-010 seq_o_ll LLB, seq_o_ml MLB, seq_o_offset OFB, seq_o_overlap MLB outputs; fields of emitted slot.
REQ-011 seq_o_first output 1 (first beat of packet); seq_o_last output 1 (final beat of packet); seq_o_null output 1 (beat carries no sequence).
REQ-012 seq_o_eoj, seq_o_delim outputs 1; packet flags, asserted only on the seq_o_last beat.
REQ-013 job_count, seq_count outputs COUNT_BITS; completed jobs, emitted sequences.

Function
REQ-014 SHALL hold at most one packet in an internal buffer with a remaining-mask register; states EMPTY and DRAIN.
REQ-015 EMPTY: bus_i_ready=1; on bus_i_valid&&bus_i_ready capture all fields, go to DRAIN with remaining-mask=bus_i_mask.
REQ-016 Packet with bus_i_mask=0 and eoj=0 and delim=0 SHALL be consumed and dropped, stay in EMPTY, no output beat.
REQ-017 Packet with bus_i_mask=0 and (eoj or delim) SHALL produce exactly one beat with seq_o_null=1, first=1, last=1, flags copied, ll/ml/offset=0.
REQ-018 DRAIN: seq_o_valid=1; emitted slot = lowest set bit of remaining-mask; slots emitted in ascending index, zero slots skipped, no bubbles.
REQ-019 seq_o_overlap SHALL equal captured overlap on the first beat and 0 on all other beats.
REQ-020 seq_o_last=1 when remaining-mask has exactly one set bit (or null beat).
REQ-021 On seq_o_valid&&seq_o_ready clear emitted bit; on last beat return to EMPTY.
REQ-022 Outputs SHALL hold stable while seq_o_valid=1 and seq_o_ready=0.
REQ-023 bus_i_ready SHALL also be 1 in DRAIN during an accepted last beat, allowing back-to-back capture; then state stays DRAIN with the new packet.
REQ-024 bus_i_ready SHALL be 0 in DRAIN otherwise; bus_i_ready SHALL NOT depend combinationally on bus_i_valid.
REQ-025 Latency: packet accepted in cycle t -> first beat valid in cycle t+1; n-set-bit packet drains in n accepted beats.
REQ-026 seq_count SHALL increment by 1 per accepted non-null beat; job_count by 1 per accepted beat with seq_o_eoj=1; both wrap modulo 2^COUNT_BITS.

Reset
REQ-027 rst asserted SHALL immediately force EMPTY, clear buffer and remaining-mask, seq_o_valid=0, job_count=0, seq_count=0, bus_i_ready=1 once rst deasserts.
REQ-028 Reset mid-DRAIN SHALL discard the packet without emitting further beats or counting it.
REQ-029 All other outputs SHALL read 0 during reset.

Verification
REQ-030 Mask 4'b1011 (P=4), ll={4,3,2,1}, overlap=5, eoj=1, seq_o_ready=1 -> beats slot0,1,3 on cycles t+1..t+3; first on slot0 with overlap 5; last+eoj on slot3; seq_count=3, job_count=1.
REQ-031 Mask 0, eoj=1 -> single null beat first=last=eoj=1; seq_count unchanged, job_count+1. Mask 0, eoj=0, delim=0 -> no beat, bus_i_ready stays 1.
REQ-032 Two packets mask 4'b0001 back-to-back with ready=1 -> one beat per cycle, no bubble; bus_i_ready=1 every cycle.
REQ-033 seq_o_ready toggled 0/1 randomly over mask 4'b1111 -> four beats, fields stable while stalled, bus_i_ready=0 until last beat accepted.
REQ-034 rst pulse between beats 2 and 3 of mask 4'b1111 -> seq_o_valid=0 at once, counters 0, next packet drains normally.
REQ-035 COUNT_BITS=2, five single-sequence eoj packets -> job_count reads 1 (wrap), seq_count reads 1.

Source files
------------

// File: rtl/seq_packet_bus_sink.sv
// Sequence packet bus sink: buffers one packet from the last bus node and
// drains its populated slots as individual sequence beats, lowest slot first.
// Packets with no sequences but a job/block flag become a single null beat.

`ifndef SEQ_PACKET_SIZE
`define SEQ_PACKET_SIZE 4
`endif
`ifndef SEQ_LL_BITS
`define SEQ_LL_BITS 8
`endif
`ifndef SEQ_ML_BITS
`define SEQ_ML_BITS 8
`endif
`ifndef SEQ_OFFSET_BITS
`define SEQ_OFFSET_BITS 16
`endif

module seq_packet_bus_sink #(
    parameter  int COUNT_BITS = 32,
    localparam int P          = `SEQ_PACKET_SIZE,
    localparam int LLB        = `SEQ_LL_BITS,
    localparam int MLB        = `SEQ_ML_BITS,
    localparam int OFB        = `SEQ_OFFSET_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  bus_i_valid,
    input  logic [P-1:0]          bus_i_mask,
    input  logic [LLB*P-1:0]      bus_i_ll,
    input  logic [MLB*P-1:0]      bus_i_ml,
    input  logic [OFB*P-1:0]      bus_i_offset,
    input  logic [MLB-1:0]        bus_i_overlap,
    input  logic                  bus_i_eoj,
    input  logic                  bus_i_delim,
    output logic                  bus_i_ready,
    output logic                  seq_o_valid,
    input  logic                  seq_o_ready,
    output logic [LLB-1:0]        seq_o_ll,
    output logic [MLB-1:0]        seq_o_ml,
    output logic [OFB-1:0]        seq_o_offset,
    output logic [MLB-1:0]        seq_o_overlap,
    output logic                  seq_o_first,
    output logic                  seq_o_last,
    output logic                  seq_o_null,
    output logic                  seq_o_eoj,
    output logic                  seq_o_delim,
    output logic [COUNT_BITS-1:0] job_count,
    output logic [COUNT_BITS-1:0] seq_count
);

    typedef enum logic {EMPTY, DRAIN} state_t;

    state_t state, state_nxt;

    // Packet buffer; rem_p0 holds the slots not yet emitted.
    logic [P-1:0]     rem_p0;
    logic [LLB*P-1:0] ll_p0;
    logic [MLB*P-1:0] ml_p0;
    logic [OFB*P-1:0] off_p0;
    logic [MLB-1:0]   ovl_p0;
    logic             eoj_p0;
    logic             delim_p0;
    logic             first_p0;

    logic accept;
    logic beat;
    logic drop;
    logic is_null;
    logic last_beat;
    logic [P-1:0] onehot;

    assign accept    = bus_i_valid && bus_i_ready;
    assign beat      = seq_o_valid && seq_o_ready;
    assign drop      = (bus_i_mask == '0) && !bus_i_eoj && !bus_i_delim;
    assign is_null   = (rem_p0 == '0);
    // Null beat, or exactly one slot left, means this beat ends the packet.
    assign last_beat = is_null || ((rem_p0 & (rem_p0 - P'(1))) == '0);
    assign onehot    = rem_p0 & (~rem_p0 + P'(1));

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= EMPTY;
        else     state <= state_nxt;
    end

    // Next state and handshake signals; ready never looks at bus_i_valid.
    always_comb begin
        state_nxt   = state;
        seq_o_valid = 1'b0;
        bus_i_ready = 1'b0;
        case (state)
            EMPTY: begin
                bus_i_ready = !rst;
                if (accept && !drop) state_nxt = DRAIN;
            end
            DRAIN: begin
                seq_o_valid = 1'b1;
                bus_i_ready = !rst && seq_o_ready && last_beat;
                if (beat && last_beat) state_nxt = (accept && !drop) ? DRAIN : EMPTY;
            end
            default: state_nxt = EMPTY;
        endcase
    end

    // Select the fields of the lowest remaining slot; null beats read zero.
    always_comb begin
        seq_o_ll     = '0;
        seq_o_ml     = '0;
        seq_o_offset = '0;
        for (int k = P - 1; k >= 0; k--) begin
            if (rem_p0[k]) begin
                seq_o_ll     = ll_p0[k*LLB +: LLB];
                seq_o_ml     = ml_p0[k*MLB +: MLB];
                seq_o_offset = off_p0[k*OFB +: OFB];
            end
        end
    end

    assign seq_o_first   = seq_o_valid && first_p0;
    assign seq_o_last    = seq_o_valid && last_beat;
    assign seq_o_null    = seq_o_valid && is_null;
    assign seq_o_eoj     = seq_o_last && eoj_p0;
    assign seq_o_delim   = seq_o_last && delim_p0;
    assign seq_o_overlap = seq_o_first ? ovl_p0 : '0;

    // Capture a new packet, or retire the emitted slot on each accepted beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_p0   <= '0;
            ll_p0    <= '0;
            ml_p0    <= '0;
            off_p0   <= '0;
            ovl_p0   <= '0;
            eoj_p0   <= 1'b0;
            delim_p0 <= 1'b0;
            first_p0 <= 1'b0;
        end else if (accept) begin
            rem_p0   <= bus_i_mask;
            ll_p0    <= bus_i_ll;
            ml_p0    <= bus_i_ml;
            off_p0   <= bus_i_offset;
            ovl_p0   <= bus_i_overlap;
            eoj_p0   <= bus_i_eoj;
            delim_p0 <= bus_i_delim;
            first_p0 <= 1'b1;
        end else if (beat) begin
            rem_p0   <= rem_p0 & ~onehot;
            first_p0 <= 1'b0;
        end
    end

    // Sequence and job counters, wrapping at their width.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_count <= '0;
            job_count <= '0;
        end else if (beat) begin
            if (!is_null) seq_count <= seq_count + COUNT_BITS'(1);
            if (seq_o_eoj) job_count <= job_count + COUNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_seq_packet_bus_sink.sv
// Directed bench for seq_packet_bus_sink with P=4, LL=8, ML=8, OFFSET=16
// and 2-bit counters so counter wrap is reachable.

module tb_seq_packet_bus_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic        bus_i_valid;
    logic [3:0]  bus_i_mask;
    logic [31:0] bus_i_ll;
    logic [31:0] bus_i_ml;
    logic [63:0] bus_i_offset;
    logic [7:0]  bus_i_overlap;
    logic        bus_i_eoj;
    logic        bus_i_delim;
    logic        bus_i_ready;
    logic        seq_o_valid;
    logic        seq_o_ready;
    logic [7:0]  seq_o_ll;
    logic [7:0]  seq_o_ml;
    logic [15:0] seq_o_offset;
    logic [7:0]  seq_o_overlap;
    logic        seq_o_first;
    logic        seq_o_last;
    logic        seq_o_null;
    logic        seq_o_eoj;
    logic        seq_o_delim;
    logic [1:0]  job_count;
    logic [1:0]  seq_count;

    int passed = 0;
    int total  = 0;

    seq_packet_bus_sink #(.COUNT_BITS(2)) dut (
        .clk(clk), .rst(rst),
        .bus_i_valid(bus_i_valid), .bus_i_mask(bus_i_mask), .bus_i_ll(bus_i_ll),
        .bus_i_ml(bus_i_ml), .bus_i_offset(bus_i_offset), .bus_i_overlap(bus_i_overlap),
        .bus_i_eoj(bus_i_eoj), .bus_i_delim(bus_i_delim), .bus_i_ready(bus_i_ready),
        .seq_o_valid(seq_o_valid), .seq_o_ready(seq_o_ready), .seq_o_ll(seq_o_ll),
        .seq_o_ml(seq_o_ml), .seq_o_offset(seq_o_offset), .seq_o_overlap(seq_o_overlap),
        .seq_o_first(seq_o_first), .seq_o_last(seq_o_last), .seq_o_null(seq_o_null),
        .seq_o_eoj(seq_o_eoj), .seq_o_delim(seq_o_delim),
        .job_count(job_count), .seq_count(seq_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic send(input logic [3:0] mask, input logic [31:0] ll, input logic [31:0] ml,
                        input logic [63:0] off, input logic [7:0] ovl,
                        input logic eoj, input logic delim);
        bus_i_valid   = 1'b1;
        bus_i_mask    = mask;
        bus_i_ll      = ll;
        bus_i_ml      = ml;
        bus_i_offset  = off;
        bus_i_overlap = ovl;
        bus_i_eoj     = eoj;
        bus_i_delim   = delim;
    endtask

    task automatic idle();
        bus_i_valid   = 1'b0;
        bus_i_mask    = '0;
        bus_i_ll      = '0;
        bus_i_ml      = '0;
        bus_i_offset  = '0;
        bus_i_overlap = '0;
        bus_i_eoj     = 1'b0;
        bus_i_delim   = 1'b0;
    endtask

    task automatic chk_beat(input string tag, input logic [7:0] ll, input logic [15:0] off,
                            input logic [7:0] ovl, input logic first, input logic last,
                            input logic eoj, input logic nul);
        chk({tag, "_valid"}, seq_o_valid, 1'b1);
        chk({tag, "_ll"}, seq_o_ll, ll);
        chk({tag, "_offset"}, seq_o_offset, off);
        chk({tag, "_overlap"}, seq_o_overlap, ovl);
        chk({tag, "_first"}, seq_o_first, first);
        chk({tag, "_last"}, seq_o_last, last);
        chk({tag, "_eoj"}, seq_o_eoj, eoj);
        chk({tag, "_null"}, seq_o_null, nul);
    endtask

    initial begin
        logic [7:0] hold_ll;
        logic [15:0] hold_off;
        int idx;
        logic [7:0] pattern;

        rst = 1'b1;
        seq_o_ready = 1'b0;
        idle();
        tick();
        tick();
        chk("rst_valid", seq_o_valid, 1'b0);
        chk("rst_last", seq_o_last, 1'b0);
        chk("rst_seq_count", seq_count, 2'd0);
        chk("rst_job_count", job_count, 2'd0);
        rst = 1'b0;
        settle();
        chk("post_rst_ready", bus_i_ready, 1'b1);

        // Mask 1011, eoj, overlap 5: slots 0,1,3.
        tick();
        seq_o_ready = 1'b1;
        send(4'b1011, 32'h04030201, 32'h14131211, 64'h0034_0033_0032_0031, 8'd5, 1'b1, 1'b0);
        settle();
        chk("t1_capture_ready", bus_i_ready, 1'b1);
        chk("t1_capture_valid", seq_o_valid, 1'b0);
        tick();
        idle();
        settle();
        chk_beat("t1_b0", 8'h01, 16'h0031, 8'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("t1_b0_ml", seq_o_ml, 8'h11);
        chk("t1_b0_ready", bus_i_ready, 1'b0);
        tick();
        settle();
        chk_beat("t1_b1", 8'h02, 16'h0032, 8'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        chk_beat("t1_b3", 8'h04, 16'h0034, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        chk("t1_b3_ml", seq_o_ml, 8'h14);
        chk("t1_b3_ready", bus_i_ready, 1'b1);
        tick();
        settle();
        chk("t1_done_valid", seq_o_valid, 1'b0);
        chk("t1_seq_count", seq_count, 2'd3);
        chk("t1_job_count", job_count, 2'd1);

        // Empty packet with eoj: one null beat.
        send(4'b0000, 32'hAABBCCDD, 32'h11223344, 64'h1, 8'd0, 1'b1, 1'b0);
        tick();
        idle();
        settle();
        chk_beat("t2_null", 8'h00, 16'h0000, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1);
        chk("t2_null_ml", seq_o_ml, 8'h00);
        tick();
        settle();
        chk("t2_done_valid", seq_o_valid, 1'b0);
        chk("t2_seq_count", seq_count, 2'd3);
        chk("t2_job_count", job_count, 2'd2);

        // Empty packet without flags: dropped silently.
        send(4'b0000, 32'h0, 32'h0, 64'h0, 8'd0, 1'b0, 1'b0);
        settle();
        chk("t2_drop_ready_in", bus_i_ready, 1'b1);
        tick();
        idle();
        settle();
        chk("t2_drop_valid", seq_o_valid, 1'b0);
        chk("t2_drop_ready", bus_i_ready, 1'b1);
        chk("t2_drop_seq_count", seq_count, 2'd3);

        // Two single-slot packets back to back.
        send(4'b0001, 32'h00000011, 32'h0, 64'h0, 8'd0, 1'b0, 1'b0);
        tick();
        send(4'b0001, 32'h00000022, 32'h0, 64'h0, 8'd0, 1'b0, 1'b0);
        settle();
        chk_beat("t3_a", 8'h11, 16'h0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_a_ready", bus_i_ready, 1'b1);
        tick();
        idle();
        settle();
        chk_beat("t3_b", 8'h22, 16'h0, 8'd0, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("t3_b_ready", bus_i_ready, 1'b1);
        tick();
        settle();
        chk("t3_done_valid", seq_o_valid, 1'b0);
        chk("t3_seq_count", seq_count, 2'd1);
        chk("t3_job_count", job_count, 2'd2);

        // Mask 1111 with a stalling consumer, delim flag.
        seq_o_ready = 1'b0;
        send(4'b1111, 32'h04030201, 32'h0, 64'h0004_0003_0002_0001, 8'd7, 1'b0, 1'b1);
        tick();
        idle();
        pattern = 8'b1011_0010;
        idx = 0;
        hold_ll = 8'h00;
        hold_off = 16'h0;
        for (int c = 0; c < 8; c++) begin
            seq_o_ready = pattern[c];
            settle();
            if (idx < 4) begin
                chk("t4_valid", seq_o_valid, 1'b1);
                chk("t4_ll", seq_o_ll, 8'(idx + 1));
                chk("t4_offset", seq_o_offset, 16'(idx + 1));
                chk("t4_first", seq_o_first, (idx == 0));
                chk("t4_last", seq_o_last, (idx == 3));
                chk("t4_delim", seq_o_delim, (idx == 3));
                chk("t4_overlap", seq_o_overlap, (idx == 0) ? 8'd7 : 8'd0);
                chk("t4_ready", bus_i_ready, (pattern[c] && idx == 3));
                if (c > 0 && !pattern[c-1]) begin
                    chk("t4_stall_ll", seq_o_ll, hold_ll);
                    chk("t4_stall_offset", seq_o_offset, hold_off);
                end
                hold_ll = seq_o_ll;
                hold_off = seq_o_offset;
                if (pattern[c]) idx++;
            end
            tick();
        end
        seq_o_ready = 1'b1;
        settle();
        chk("t4_beats", idx, 4);
        chk("t4_done_valid", seq_o_valid, 1'b0);
        chk("t4_seq_count", seq_count, 2'd1);
        chk("t4_job_count", job_count, 2'd2);

        // Reset in the middle of a 4-slot packet.
        send(4'b1111, 32'h04030201, 32'h0, 64'h0004_0003_0002_0001, 8'd0, 1'b1, 1'b0);
        tick();
        idle();
        tick();
        tick();
        settle();
        chk("t5_pre_ll", seq_o_ll, 8'h03);
        #1;
        rst = 1'b1;
        #1;
        chk("t5_rst_valid", seq_o_valid, 1'b0);
        chk("t5_rst_seq_count", seq_count, 2'd0);
        chk("t5_rst_job_count", job_count, 2'd0);
        chk("t5_rst_ll", seq_o_ll, 8'h00);
        tick();
        rst = 1'b0;
        settle();
        chk("t5_post_valid", seq_o_valid, 1'b0);
        chk("t5_post_ready", bus_i_ready, 1'b1);
        send(4'b0101, 32'h04030201, 32'h0, 64'h0004_0003_0002_0001, 8'd9, 1'b1, 1'b0);
        tick();
        idle();
        settle();
        chk_beat("t5_b0", 8'h01, 16'h0001, 8'd9, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        settle();
        chk_beat("t5_b2", 8'h03, 16'h0003, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        settle();
        chk("t5_seq_count", seq_count, 2'd2);
        chk("t5_job_count", job_count, 2'd1);

        // Counter wrap: five single-sequence eoj packets from a clean reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        send(4'b0001, 32'h5, 32'h0, 64'h0, 8'd0, 1'b1, 1'b0);
        for (int n = 0; n < 5; n++) begin
            settle();
            chk("t6_ready", bus_i_ready, 1'b1);
            tick();
        end
        idle();
        tick();
        settle();
        chk("t6_valid", seq_o_valid, 1'b0);
        chk("t6_job_count", job_count, 2'd1);
        chk("t6_seq_count", seq_count, 2'd1);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
